// File: rtl/conv_window_feeder_if.sv
// Handshake and bus bundle between a pixel/weight source and the window feeder.
// The master side drives pixels and weights; the slave side presents windows to the array.
interface conv_window_feeder_if #(
  parameter int WORDWIDTH = 32,
  parameter int ARRAYLEN  = 25
);
  logic                 start;
  logic                 reuse_w;
  logic [WORDWIDTH-1:0] w_in;
  logic                 w_valid;
  logic [WORDWIDTH-1:0] pix_in;
  logic                 pix_valid;
  logic                 pix_ready;
  logic [WORDWIDTH-1:0] F [ARRAYLEN-1:0];
  logic [WORDWIDTH-1:0] W [ARRAYLEN-1:0];
  logic                 in_valid;
  logic                 busy;
  logic                 frame_done;

  modport master (
    output start, reuse_w, w_in, w_valid, pix_in, pix_valid,
    input  pix_ready, F, W, in_valid, busy, frame_done
  );

  modport slave (
    input  start, reuse_w, w_in, w_valid, pix_in, pix_valid,
    output pix_ready, F, W, in_valid, busy, frame_done
  );
endinterface

// File: rtl/conv_window_feeder.sv
// Raster pixel stream -> KSIZE x KSIZE sliding windows (valid padding) for the systolic array.
// KSIZE-1 line buffers feed the right column of the window; weights load serially into W.
module conv_window_feeder #(
  parameter int WORDWIDTH = 32,
  parameter int KSIZE     = 5,
  parameter int ARRAYLEN  = 25,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conv_window_feeder_if.slave  bus
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int KW = (ARRAYLEN > 1) ? $clog2(ARRAYLEN) : 1;

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DONE} state_t;

  state_t state, state_nxt;

  logic [RW-1:0]        r;
  logic [CW-1:0]        c;
  logic [KW-1:0]        wcnt;
  logic [WORDWIDTH-1:0] win [ARRAYLEN-1:0];
  logic [WORDWIDTH-1:0] wt  [ARRAYLEN-1:0];
  logic [WORDWIDTH-1:0] lb  [KSIZE-1][IMG_W];
  logic                 v_q;
  logic                 accept, last_pix, win_ok;

  assign accept   = (state == STREAM) && bus.pix_valid;
  assign last_pix = (r == RW'(IMG_H-1)) && (c == CW'(IMG_W-1));
  assign win_ok   = (r >= RW'(KSIZE-1)) && (c >= CW'(KSIZE-1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.pix_ready  = 1'b0;
    bus.busy       = 1'b1;
    bus.frame_done = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_nxt = bus.reuse_w ? STREAM : LOAD_W;
      end
      LOAD_W: if (bus.w_valid && wcnt == KW'(ARRAYLEN-1)) state_nxt = STREAM;
      STREAM: begin
        bus.pix_ready = 1'b1;
        if (accept && last_pix) state_nxt = DONE;
      end
      DONE: begin
        bus.frame_done = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r    <= '0;
      c    <= '0;
      wcnt <= '0;
      v_q  <= 1'b0;
      for (int k = 0; k < ARRAYLEN; k++) begin
        win[k] <= '0;
        wt[k]  <= '0;
      end
    end else begin
      v_q <= accept && win_ok;

      if (state != LOAD_W) wcnt <= '0;
      else if (bus.w_valid) begin
        wt[wcnt] <= bus.w_in;
        wcnt     <= wcnt + 1'b1;
      end

      // Counters park at zero outside STREAM so every frame starts at (0,0).
      if (state != STREAM) begin
        r <= '0;
        c <= '0;
      end else if (accept) begin
        if (c == CW'(IMG_W-1)) begin
          c <= '0;
          r <= r + 1'b1;
        end else begin
          c <= c + 1'b1;
        end
      end

      if (accept) begin
        for (int i = 0; i < KSIZE; i++)
          for (int j = 0; j < KSIZE-1; j++)
            win[i*KSIZE+j] <= win[i*KSIZE+j+1];
        for (int i = 0; i < KSIZE-1; i++)
          win[i*KSIZE+KSIZE-1] <= lb[i][c];
        win[ARRAYLEN-1] <= bus.pix_in;
      end
    end
  end

  // lb[0] holds the oldest row (r-KSIZE+1), lb[KSIZE-2] the previous row; no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < KSIZE-2; i++)
        lb[i][c] <= lb[i+1][c];
      lb[KSIZE-2][c] <= bus.pix_in;
    end
  end

  assign bus.F        = win;
  assign bus.W        = wt;
  assign bus.in_valid = v_q;
endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: 6x6 frame, 3x3 kernel, scoreboard of expected windows
// plus a table of frame scenarios and hand-written reset sequences.
module tb_conv_window_feeder;
  localparam int WW = 32, K = 3, AL = 9, IW = 6, IH = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_window_feeder_if #(.WORDWIDTH(WW), .ARRAYLEN(AL)) bus();

  conv_window_feeder #(
    .WORDWIDTH(WW), .KSIZE(K), .ARRAYLEN(AL), .IMG_W(IW), .IMG_H(IH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct { int v[AL]; } exp_t;
  typedef struct {
    int gap;
    bit reuse;
    bit stray;
    int nwin;
    int first[AL];
    int last[AL];
  } vec_t;

  vec_t tbl[4];
  exp_t sb[$];
  int   tests = 0, fails = 0;
  int   nwin, cur_r, cur_c;
  bit   w_loaded;
  int   firstw[AL], lastw[AL];

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic int nz_f();
    int n = 0;
    for (int k = 0; k < AL; k++) if (bus.F[k] != '0) n++;
    return n;
  endfunction

  function automatic int nz_w();
    int n = 0;
    for (int k = 0; k < AL; k++) if (bus.W[k] != '0) n++;
    return n;
  endfunction

  function automatic int ndiff(input int a[AL], input int b[AL]);
    int n = 0;
    for (int k = 0; k < AL; k++) if (a[k] != b[k]) n++;
    return n;
  endfunction

  // One clock: predict from the inputs now applied, advance, then check outputs.
  task automatic tick();
    bit   acc, want_v, want_done, ok;
    int   bad_w;
    exp_t e;
    acc       = rst_n && bus.pix_valid && bus.pix_ready;
    want_v    = acc && cur_r >= K-1 && cur_c >= K-1;
    want_done = acc && cur_r == IH-1 && cur_c == IW-1;
    if (want_v) begin
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          e.v[i*K+j] = (cur_r-K+1+i)*IW + (cur_c-K+1+j);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    chk("in_valid", int'(bus.in_valid), int'(want_v));
    chk("frame_done", int'(bus.frame_done), int'(want_done));
    if (bus.in_valid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL window: in_valid with no expected window, F[0]=%0d", bus.F[0]);
      end else begin
        e  = sb.pop_front();
        ok = 1'b1;
        for (int k = 0; k < AL; k++) if (bus.F[k] !== WW'(e.v[k])) ok = 1'b0;
        if (!ok) begin
          fails++;
          $display("FAIL window %0d: got F[0]=%0d F[4]=%0d F[8]=%0d, expected %0d %0d %0d",
                   nwin, bus.F[0], bus.F[4], bus.F[8], e.v[0], e.v[4], e.v[8]);
        end
        for (int k = 0; k < AL; k++) begin
          if (nwin == 0) firstw[k] = int'(bus.F[k]);
          lastw[k] = int'(bus.F[k]);
        end
        nwin++;
      end
    end
    if (w_loaded) begin
      bad_w = 0;
      for (int k = 0; k < AL; k++) if (bus.W[k] !== WW'(k+1)) bad_w++;
      chk("W_hold", bad_w, 0);
    end
    @(negedge clk);
  endtask

  task automatic run_frame(input int gap, input bit reuse, input bit stray, input int stop_after);
    int guard;
    nwin = 0;
    for (int k = 0; k < AL; k++) begin firstw[k] = -1; lastw[k] = -1; end
    bus.start = 1'b1; bus.reuse_w = reuse;
    tick();
    bus.start = 1'b0; bus.reuse_w = 1'b0;
    chk("busy_after_start", int'(bus.busy), 1);
    chk("pix_ready_after_start", int'(bus.pix_ready), int'(reuse));
    if (!reuse) begin
      w_loaded = 1'b0;
      for (int k = 0; k < AL; k++) begin
        if (gap > 0 && $urandom_range(99) < gap) begin
          bus.w_valid = 1'b0; tick();
        end
        bus.w_valid = 1'b1; bus.w_in = WW'(k+1);
        tick();
        bus.w_valid = 1'b0;
        chk("pix_ready_load", int'(bus.pix_ready), int'(k == AL-1));
      end
      w_loaded = 1'b1;
    end
    for (int idx = 0; idx < IW*IH; idx++) begin
      cur_r = idx / IW;
      cur_c = idx % IW;
      guard = 0;
      while (gap > 0 && $urandom_range(99) < gap && guard < 8) begin
        bus.pix_valid = 1'b0; bus.pix_in = $urandom;
        tick();
        guard++;
      end
      bus.pix_valid = 1'b1; bus.pix_in = WW'(idx);
      if (stray && idx % 7 == 3) begin
        bus.start = 1'b1; bus.w_valid = 1'b1; bus.w_in = WW'(99);
      end
      chk("pix_ready", int'(bus.pix_ready), 1);
      tick();
      bus.pix_valid = 1'b0; bus.start = 1'b0; bus.w_valid = 1'b0;
      if (idx == stop_after) return;
    end
    tick();
    chk("busy_end", int'(bus.busy), 0);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int f0[AL] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
    int l0[AL] = '{21, 22, 23, 27, 28, 29, 33, 34, 35};
    bus.start = 1'b0; bus.reuse_w = 1'b0; bus.w_in = '0; bus.w_valid = 1'b0;
    bus.pix_in = '0; bus.pix_valid = 1'b0;
    w_loaded = 1'b0; cur_r = 0; cur_c = 0; nwin = 0;

    // gap%, reuse, stray pulses, expected window count / first / last window
    tbl[0].gap = 0;  tbl[0].reuse = 1'b0; tbl[0].stray = 1'b0;
    tbl[1].gap = 50; tbl[1].reuse = 1'b0; tbl[1].stray = 1'b0;
    tbl[2].gap = 0;  tbl[2].reuse = 1'b1; tbl[2].stray = 1'b0;
    tbl[3].gap = 0;  tbl[3].reuse = 1'b1; tbl[3].stray = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tbl[t].nwin = (IH-K+1)*(IW-K+1);
      tbl[t].first = f0;
      tbl[t].last  = l0;
    end

    @(negedge clk);
    tick(); tick();
    chk("rst_in_valid", int'(bus.in_valid), 0);
    chk("rst_pix_ready", int'(bus.pix_ready), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_F", nz_f(), 0);
    chk("rst_W", nz_w(), 0);
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 4; t++) begin
      run_frame(tbl[t].gap, tbl[t].reuse, tbl[t].stray, -1);
      chk("nwin", nwin, tbl[t].nwin);
      chk("first_window", ndiff(firstw, tbl[t].first), 0);
      chk("last_window", ndiff(lastw, tbl[t].last), 0);
    end

    // Reset in the middle of a frame, after pixel 20 has been accepted.
    run_frame(0, 1'b1, 1'b0, 20);
    w_loaded = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_F", nz_f(), 0);
    chk("midrst_W", nz_w(), 0);
    chk("midrst_sb", sb.size(), 0);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_pix_ready", int'(bus.pix_ready), 0);
    run_frame(0, 1'b0, 1'b0, -1);
    chk("nwin_after_rst", nwin, tbl[0].nwin);
    chk("first_after_rst", ndiff(firstw, tbl[0].first), 0);
    chk("last_after_rst", ndiff(lastw, tbl[0].last), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Producer side of the systolic dot-product array. Supplies its F (feature window), W (kernel) and in_valid inputs.
- Takes in a raster-order pixel stream of one input feature map, one pixel per handshake.
- Holds KSIZE-1 line buffers plus a KSIZE x KSIZE window register and presents one full window per accepted pixel once the window is filled (valid-padding convolution).
- Kernel weights are loaded serially and held on W until the next load.

Parameters:
- WORDWIDTH, 32, width of pixel and weight words.
- KSIZE, 5, kernel side length.
- ARRAYLEN, 25, window length; must equal KSIZE*KSIZE.
- IMG_W, 28, feature-map width in pixels (IMG_W >= KSIZE).
- IMG_H, 28, feature-map height in pixels (IMG_H >= KSIZE).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin a frame; sampled only in IDLE.
- reuse_w  in  1  sampled with start; 1 = skip weight load and keep current W.
- w_in  in  WORDWIDTH  serial weight word.
- w_valid  in  1  w_in valid; accepted only in LOAD_W.
- pix_in  in  WORDWIDTH  raster-order pixel.
- pix_valid  in  1  pix_in valid.
- pix_ready  out  1  feeder accepts a pixel; a pixel transfers when pix_valid & pix_ready.
- F  out  WORDWIDTH x ARRAYLEN (unpacked array [WORDWIDTH-1:0] F[ARRAYLEN-1:0])  window to the array.
- W  out  WORDWIDTH x ARRAYLEN (same shape)  kernel to the array.
- in_valid  out  1  F/W hold a valid window this cycle.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset: state=IDLE. Row/col/weight counters = 0. Window registers, F, W = 0. in_valid, pix_ready, busy, frame_done = 0. Line-buffer contents are not reset. Reset mid-frame aborts the frame; no further in_valid until a new start.
- States:
  - IDLE.
    - start & !reuse_w -> LOAD_W.
    - start & reuse_w -> STREAM.
  - LOAD_W.
    - Each w_valid stores w_in into W[k], k = 0..ARRAYLEN-1 in arrival order.
    - After the ARRAYLEN-th word -> STREAM. w_valid gaps are allowed.
  - STREAM.
    - pix_ready=1.
    - Accepting the pixel at (r=IMG_H-1, c=IMG_W-1) -> DONE.
  - DONE.
    - One cycle; frame_done=1, pix_ready=0.
    - -> IDLE.
- Ignored inputs:
  - start outside IDLE is ignored.
  - w_valid outside LOAD_W is ignored.
  - pix_valid outside STREAM is ignored (pix_ready=0 there).
- Counters: c increments on each accepted pixel, wraps at IMG_W-1 to 0 and increments r. r, c clear on entering STREAM.
- On an accepted pixel at (r,c):
  - Window shifts one column left.
  - New rightmost column = line-buffer words at column c for rows r-KSIZE+1..r-1, plus pix_in as bottom element.
  - Line buffers update at column c (row shift up, pix_in written to newest row).
- Window mapping: F[i*KSIZE+j] = pixel(r-KSIZE+1+i, c-KSIZE+1+j), i,j = 0..KSIZE-1.
- Latency: F and in_valid are registered. in_valid=1 in the cycle after accepting a pixel with r>=KSIZE-1 and c>=KSIZE-1; otherwise 0.
- Windows per frame: exactly (IMG_H-KSIZE+1)*(IMG_W-KSIZE+1). Windows never straddle a row wrap.
- Pixel gaps: pix_valid=0 leaves the window unchanged and gives in_valid=0 next cycle. There is no downstream backpressure; the array accepts every cycle.
- frame_done coincides with the in_valid of the last window.
- W holds its value across frames and is stable during STREAM.
- No arithmetic is performed; words pass through unmodified.

Test Plan:
- Overrides KSIZE=3, ARRAYLEN=9, IMG_W=IMG_H=6. Pixel value = r*6+c.
- Load weights 1..9, stream the full frame without gaps:
  - W[0]=1 and W[8]=9 throughout.
  - First in_valid is the cycle after pixel 14. F = {0,1,2,6,7,8,12,13,14}.
  - Exactly 16 in_valid pulses; last F = {21,22,23,27,28,29,33,34,35}.
  - frame_done on the same cycle as the last in_valid.
- Random pix_valid gaps (~50%): same 16 windows in the same order. in_valid never asserted without a preceding accept.
- Second frame with start & reuse_w=1: no LOAD_W, W still 1..9, pix_ready high the cycle after start, same 16 windows.
- rst_n=0 after pixel 20 of a frame: next cycle in_valid=0, busy=0, F=W=0. New start + full frame reproduces the scenario-1 windows.
- start pulsed during STREAM and w_valid pulsed during STREAM: no state change, W unchanged, window sequence identical to scenario 1.
